// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, redirect flush, data-hazard stall and EX operand forwarding.
// Build option: define HAZARD_FORWARD_EN for load-use stalls plus forwarding; undefined stalls on any RAW match.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_RegWrite,
    input  logic             EX_mem_read,
    input  logic [4:0]       MEM_rd,
    input  logic             MEM_RegWrite,
    input  logic [4:0]       WB_rd,
    input  logic             WB_RegWrite,
    input  logic             EX_redirect,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_stall,
    output logic             MEM_WB_flush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             pending_reg;
    logic             pending_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic [4:0] src_rs  [2];
    logic       src_use [2];
    logic [1:0] hit_ex;
    logic [1:0] hit_mem;
    logic [1:0] hit_wb;
    logic [1:0] fwd_sel [2];

    logic   mem_wait;
    logic   data_stall;
    state_t data_state;

    assign src_rs[0]  = ID_rs1;
    assign src_rs[1]  = ID_rs2;
    assign src_use[0] = ID_use_rs1;
    assign src_use[1] = ID_use_rs2;

    // x0 is hard-wired zero, so a write to it never produces a dependency.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign hit_ex[gi]  = src_use[gi] && EX_RegWrite  && (EX_rd  == src_rs[gi]) && (EX_rd  != 5'd0);
            assign hit_mem[gi] = src_use[gi] && MEM_RegWrite && (MEM_rd == src_rs[gi]) && (MEM_rd != 5'd0);
            assign hit_wb[gi]  = src_use[gi] && WB_RegWrite  && (WB_rd  == src_rs[gi]) && (WB_rd  != 5'd0);
        end
    endgenerate

    assign mem_wait = dm_req && !dm_ready;

`ifdef HAZARD_FORWARD_EN
    // Only a load in EX cannot be bypassed; everything else is forwarded, youngest producer first.
    assign data_stall = EX_mem_read && (|hit_ex);
    assign data_state = LU_STALL;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = hit_mem[gi] ? 2'b10 :
                                 hit_wb[gi]  ? 2'b01 : 2'b00;
        end
    endgenerate
`else
    // Without bypass paths the ID instruction waits until every producer has retired.
    logic unused_ex_mem_read;

    assign unused_ex_mem_read = EX_mem_read;
    assign data_stall         = (|hit_ex) || (|hit_mem) || (|hit_wb);
    assign data_state         = RUN;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = 2'b00;
        end
    endgenerate
`endif

    always_comb begin
        PC_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_stall = 1'b0;
        MEM_WB_flush = 1'b0;
        ForwardA     = fwd_sel[0];
        ForwardB     = fwd_sel[1];
        state_next   = RUN;
        pending_next = pending_reg;

        if (mem_wait) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
            state_next   = MEM_WAIT;
            if (EX_redirect) begin
                pending_next = 1'b1;
            end
        end else if (state_reg == MEM_WAIT && pending_reg) begin
            // The owed redirect is taken as a dedicated flush cycle after the access completes.
            state_next = FLUSH;
        end else if (state_reg == FLUSH) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            pending_next = 1'b0;
        end else if (EX_redirect) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (data_stall) begin
            PC_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
            state_next  = data_state;
        end

        if (!reset) begin
            PC_stall     = 1'b0;
            IF_ID_stall  = 1'b0;
            IF_ID_flush  = 1'b0;
            ID_EX_flush  = 1'b0;
            EX_MEM_stall = 1'b0;
            MEM_WB_flush = 1'b0;
            ForwardA     = 2'b00;
            ForwardB     = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= RUN;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (PC_stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of stall performance counter.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
- ID_use_rs1, ID_use_rs2  in  1 each  the ID instruction reads that source.
- EX_rd  in  5;  EX_RegWrite  in  1;  EX_mem_read  in  1  destination, write enable and load flag of the instruction in EX.
- MEM_rd  in  5;  MEM_RegWrite  in  1  destination and write enable in MEM.
- WB_rd  in  5;  WB_RegWrite  in  1  destination and write enable in WB.
- EX_redirect  in  1  taken branch or jump resolved in EX.
- dm_req  in  1  MEM stage data-memory access;  dm_ready  in  1  data memory completes this cycle.
- PC_stall, IF_ID_stall  out  1  hold PC and IF/ID.
- IF_ID_flush, ID_EX_flush  out  1  insert a bubble.
- EX_MEM_stall  out  1  hold EX/MEM;  MEM_WB_flush  out  1  bubble into WB.
- ForwardA, ForwardB  out  2  operand select for EX: 00 RF, 10 EX/MEM, 01 MEM/WB.
- stall_cnt  out  CNT_W  count of cycles with PC_stall=1.

Function
REQ-003 SHALL implement FSM states RUN, LU_STALL, MEM_WAIT, FLUSH, registered on clk.
REQ-004 A source matches a stage when its use flag is 1, the stage write enable is 1, rd equals rs, and rd is not 0. Register x0 SHALL never cause a stall or a forward.
REQ-005 Priority per cycle: memory wait > redirect > data hazard.
REQ-006 Memory wait: while dm_req=1 and dm_ready=0, assert PC_stall, IF_ID_stall, EX_MEM_stall and MEM_WB_flush. Assert no other flush. Go to or stay in MEM_WAIT.
REQ-007 In MEM_WAIT, an EX_redirect=1 SHALL be latched into pending_redirect. EX_redirect is held by the frozen pipeline.
REQ-008 On dm_ready=1 in MEM_WAIT: go to FLUSH if pending_redirect=1, else go to RUN.
REQ-009 In FLUSH, for one cycle: assert IF_ID_flush and ID_EX_flush, clear pending_redirect, then go to RUN.
REQ-010 Redirect in RUN or LU_STALL with no memory wait: assert IF_ID_flush and ID_EX_flush in the same cycle, PC_stall=0, next state RUN.
REQ-011 Load-use: EX_mem_read=1 and either ID source matches EX. Assert PC_stall, IF_ID_stall and ID_EX_flush for exactly one cycle, then go to LU_STALL.
REQ-012 LU_STALL lasts one cycle, then returns to RUN, or applies REQ-005 priority to the new inputs.
REQ-013 Forwarding: a MEM match selects 10; else a WB match selects 01; else 00. Computed combinationally from ID_EX-side rs inputs each cycle.
REQ-014 stall_cnt SHALL increment on every clk with PC_stall=1 and saturate at all-ones, with no wrap.
REQ-015 Stall and flush outputs SHALL be combinational from state and inputs, with zero-cycle latency.

Reset
REQ-016 While reset=0, asynchronously: state=RUN, pending_redirect=0, stall_cnt=0, and all stall, flush and Forward outputs = 0.
REQ-017 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL discard the pending redirect. The first cycle after release SHALL be RUN.

Configuration
REQ-018 Macro HAZARD_FORWARD_EN.
- Defined: REQ-011 and REQ-013 apply.
- Undefined: ForwardA and ForwardB are tied to 00. Any match against EX, MEM or WB, load or not, asserts PC_stall, IF_ID_stall and ID_EX_flush each cycle until no match remains. The state stays RUN, and REQ-005 priority is unchanged.

Verification
REQ-019 The bench SHALL cover:
- Load-use: EX_mem_read=1, EX_rd=5, ID_rs1=5, use=1 -> one cycle of PC_stall=1 and ID_EX_flush=1; next cycle with EX cleared -> RUN, ForwardA=01 when WB_rd=5.
- Forward priority: MEM_rd=7 and WB_rd=7, both write, ID_rs2=7 -> ForwardB=10. Any match with rd=0 -> ForwardB=00, no stall.
- Memory wait plus redirect: dm_req=1, dm_ready=0 for 3 cycles with EX_redirect=1 -> 3 frozen cycles, no flush. dm_ready=1 -> next cycle FLUSH with IF_ID_flush=ID_EX_flush=1, then RUN.
- Simultaneous events: redirect and load-use in the same RUN cycle -> flushes asserted, PC_stall=0.
- Reset mid-MEM_WAIT with pending_redirect=1 -> all outputs 0; after release, no FLUSH cycle; with CNT_W=4, 20 stall cycles -> stall_cnt=15.
- HAZARD_FORWARD_EN undefined: MEM_RegWrite=1, MEM_rd=3, ID_rs1=3 -> stall while the match persists, Forward=00.
